// File: rtl/if_prefetch.sv
// Instruction-fetch front end: owns the PC, drives a combinational-read ROM and
// buffers fetched {pc, inst} pairs in a first-word-fall-through FIFO for decode.
module if_prefetch #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         rom_ce_o,
    output logic [ADDR_W-1:0]            rom_addr_o,
    input  logic [DATA_W-1:0]            rom_data_i,
    output logic                         id_valid_o,
    input  logic                         id_ready_i,
    output logic [ADDR_W-1:0]            id_pc_o,
    output logic [DATA_W-1:0]            id_inst_o,
    input  logic                         branch_flag_i,
    input  logic [ADDR_W-1:0]            branch_target_i,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_en_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];

    logic push, pop;

    // A full FIFO may still fetch when the head leaves in the same cycle.
    always_comb begin
        id_valid_o   = ~rst & (count_q != '0);
        pop          = id_valid_o & id_ready_i;
        rom_ce_o     = ce_en_q & ~rst & ~branch_flag_i & ((count_q < FULL_CNT) | pop);
        push         = rom_ce_o;
        rom_addr_o   = pc_q;
        fifo_count_o = count_q;
        id_pc_o      = id_valid_o ? pc_mem[rd_ptr_q]   : '0;
        id_inst_o    = id_valid_o ? inst_mem[rd_ptr_q] : '0;
    end

    always_comb begin
        pc_d     = pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (branch_flag_i) begin
            // Redirect to the word-aligned target; any queued entries are wrong-path.
            pc_d     = branch_target_i & ~ADDR_W'(3);
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                pc_d     = pc_q + ADDR_W'(4);
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            ce_en_q  <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ce_en_q  <= 1'b1;
            pc_q     <= pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed through a nonzero count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr_q]   <= pc_q;
            inst_mem[wr_ptr_q] <= rom_data_i;
        end
    end

endmodule

// File: tb/tb_if_prefetch.sv
// Bench for if_prefetch: queue-based reference model checked every cycle plus
// directed literal checks; a second instance covers PC wrap from a high RESET_PC.
module tb_if_prefetch;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ready = 1'b1;
    logic          br = 1'b0;
    logic [AW-1:0] tgt = '0;

    logic          rom_ce, id_valid;
    logic [AW-1:0] rom_addr, id_pc;
    logic [DW-1:0] rom_data, id_inst;
    logic [CW-1:0] fifo_count;

    logic          rom_ce2, id_valid2;
    logic [AW-1:0] rom_addr2, id_pc2;
    logic [DW-1:0] rom_data2, id_inst2;
    logic [CW-1:0] fifo_count2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_0000;
    endfunction

    assign rom_data  = rom_fn(rom_addr);
    assign rom_data2 = rom_fn(rom_addr2);

    if_prefetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .id_valid_o(id_valid), .id_ready_i(ready), .id_pc_o(id_pc), .id_inst_o(id_inst),
        .branch_flag_i(br), .branch_target_i(tgt), .fifo_count_o(fifo_count)
    );

    if_prefetch #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst(rst), .rom_ce_o(rom_ce2), .rom_addr_o(rom_addr2), .rom_data_i(rom_data2),
        .id_valid_o(id_valid2), .id_ready_i(ready), .id_pc_o(id_pc2), .id_inst_o(id_inst2),
        .branch_flag_i(br), .branch_target_i(tgt), .fifo_count_o(fifo_count2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of {pc, inst} plus the fetch PC and enable.
    logic [63:0] mq[$];
    logic [31:0] m_pc = '0;
    bit          m_ce_en = 1'b0;
    bit          m_live = 1'b0;

    function automatic bit m_valid();
        return !rst && mq.size() != 0;
    endfunction

    function automatic bit m_fetch();
        return m_ce_en && !rst && !br && (mq.size() < DEPTH || (m_valid() && ready));
    endfunction

    always @(posedge clk) begin
        bit f, p;
        f = m_fetch();
        p = m_valid() && ready;
        if (rst) begin
            mq.delete();
            m_pc    = 32'h0;
            m_ce_en = 1'b0;
        end else begin
            m_ce_en = 1'b1;
            if (br) begin
                mq.delete();
                m_pc = tgt & ~32'h3;
            end else begin
                if (p) void'(mq.pop_front());
                if (f) begin
                    mq.push_back({m_pc, rom_fn(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
        m_live = 1'b1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("m_rom_ce",   32'(rom_ce),     32'(m_fetch()));
            chk("m_rom_addr", rom_addr,        m_pc);
            chk("m_valid",    32'(id_valid),   32'(m_valid()));
            chk("m_id_pc",    id_pc,           m_valid() ? mq[0][63:32] : 32'h0);
            chk("m_id_inst",  id_inst,         m_valid() ? mq[0][31:0]  : 32'h0);
            chk("m_count",    32'(fifo_count), 32'(mq.size()));
        end
    end

    // Fetch addresses of the wrapping instance after its first reset release.
    bit          cap2 = 1'b0;
    bit          gap2 = 1'b0;
    logic [31:0] f2[$];

    always @(negedge clk) begin
        if (cap2) begin
            if (rom_ce2) f2.push_back(rom_addr2);
            else if (f2.size() > 0 && f2.size() < 4) gap2 = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] wrap_exp [4];
        wrap_exp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};

        // Reset state
        tick(); tick(); #1;
        chk("rst_ce",    32'(rom_ce), 0);
        chk("rst_valid", 32'(id_valid), 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_id_pc", id_pc, 0);
        chk("rst_inst",  id_inst, 0);
        chk("rst_addr",  rom_addr, 0);

        // Release: one idle cycle, then 1 instruction/cycle
        rst = 1'b0; cap2 = 1'b1; #1;
        chk("idle_ce", 32'(rom_ce), 0);
        tick(); #1;
        chk("f0_ce", 32'(rom_ce), 1);
        chk("f0_addr", rom_addr, 32'h0);
        chk("f0_valid", 32'(id_valid), 0);
        tick(); #1;
        chk("f1_addr", rom_addr, 32'h4);
        chk("f1_valid", 32'(id_valid), 1);
        chk("f1_id_pc", id_pc, 32'h0);
        chk("f1_inst", id_inst, 32'h1234_FFFF);
        tick(); #1;
        chk("f2_addr", rom_addr, 32'h8);
        chk("f2_id_pc", id_pc, 32'h4);
        tick(); tick(); tick();
        cap2 = 1'b0;
        chk("wrap_gap", 32'(gap2), 0);
        for (int i = 0; i < 4; i++)
            chk("wrap_addr", f2.size() > i ? f2[i] : 32'hDEAD_BEEF, wrap_exp[i]);

        // Stall from reset until full
        rst = 1'b1; ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        #1;
        chk("full_ce", 32'(rom_ce), 0);
        chk("full_addr", rom_addr, 32'h10);
        chk("full_count", 32'(fifo_count), 4);
        chk("full_id_pc", id_pc, 32'h0);
        ready = 1'b1; #1;
        chk("resume_ce", 32'(rom_ce), 1);
        chk("resume_addr", rom_addr, 32'h10);
        tick(); #1;
        chk("resume_count", 32'(fifo_count), 4);
        chk("resume_id_pc", id_pc, 32'h4);
        chk("resume_addr2", rom_addr, 32'h14);

        // Flush with three queued entries
        rst = 1'b1; ready = 1'b0;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        br = 1'b1; tgt = 32'h100; ready = 1'b1; #1;
        chk("fl_pre_count", 32'(fifo_count), 3);
        chk("fl_ce", 32'(rom_ce), 0);
        chk("fl_delay_slot", id_pc, 32'h0);
        tick();
        br = 1'b0; #1;
        chk("fl_count", 32'(fifo_count), 0);
        chk("fl_valid", 32'(id_valid), 0);
        chk("fl_addr", rom_addr, 32'h100);
        chk("fl_ce_on", 32'(rom_ce), 1);
        tick(); #1;
        chk("fl_head_pc", id_pc, 32'h100);
        chk("fl_head_inst", id_inst, 32'h1334_FEFF);

        // Unaligned target and back-to-back flushes
        br = 1'b1; tgt = 32'h103;
        tick();
        br = 1'b0; #1;
        chk("align_addr", rom_addr, 32'h100);
        br = 1'b1; tgt = 32'h200;
        tick();
        tgt = 32'h30C; #1;
        chk("fl2_ce", 32'(rom_ce), 0);
        tick();
        br = 1'b0; #1;
        chk("fl2_addr", rom_addr, 32'h30C);
        chk("fl2_count", 32'(fifo_count), 0);

        // Reset while full
        ready = 1'b0;
        repeat (6) tick();
        #1;
        chk("pre_rst_count", 32'(fifo_count), 4);
        rst = 1'b1; #1;
        chk("mrst_ce", 32'(rom_ce), 0);
        chk("mrst_valid", 32'(id_valid), 0);
        tick(); #1;
        chk("mrst_ce1", 32'(rom_ce), 0);
        chk("mrst_valid1", 32'(id_valid), 0);
        chk("mrst_count", 32'(fifo_count), 0);
        tick();
        rst = 1'b0; #1;
        chk("mrst_idle_ce", 32'(rom_ce), 0);
        chk("mrst_idle_count", 32'(fifo_count), 0);
        chk("mrst_idle_addr", rom_addr, 32'h0);
        tick(); #1;
        chk("mrst_f0_ce", 32'(rom_ce), 1);
        chk("mrst_f0_addr", rom_addr, 32'h0);

        // Mixed stall/flush traffic checked by the model
        for (int i = 0; i < 80; i++) begin
            ready = 1'($urandom_range(0, 1));
            br    = ($urandom_range(0, 9) == 0);
            tgt   = $urandom;
            tick();
        end
        br = 1'b0; ready = 1'b1;
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
